// File: rtl/shift_req_arbiter_if.sv
// rtl/shift_req_arbiter_if.sv - request/response/shifter signal bundle for shift_req_arbiter
interface shift_req_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_data;
    logic [3:0] req0_amt;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_data;
    logic [3:0] req1_amt;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_id;
    logic [7:0] sh_a;
    logic       sh_s2;
    logic       sh_s1;
    logic       sh_s0;
    logic [7:0] sh_o;
    logic       busy;

    modport master (
        input  req0_valid, req0_data, req0_amt,
        input  req1_valid, req1_data, req1_amt,
        input  resp_ready, sh_o,
        output req0_ready, req1_ready,
        output resp_valid, resp_data, resp_id,
        output sh_a, sh_s2, sh_s1, sh_s0, busy
    );

    modport slave (
        output req0_valid, req0_data, req0_amt,
        output req1_valid, req1_data, req1_amt,
        output resp_ready, sh_o,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_data, resp_id,
        input  sh_a, sh_s2, sh_s1, sh_s0, busy
    );
endinterface

// File: rtl/shift_req_arbiter.sv
// rtl/shift_req_arbiter.sv - round-robin sharing of an 8-bit external left shifter
module shift_req_arbiter #(
    parameter logic RR_INIT  = 1'b0,
    parameter int   MAX_STEP = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_req_arbiter_if.master   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    localparam logic [3:0] STEP_MAX = 4'(MAX_STEP);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_acc,   w_acc_nxt;
    logic [3:0] r_rem,   w_rem_nxt;
    logic       r_id,    w_id_nxt;
    logic       r_prio,  w_prio_nxt;

    logic       w_any;
    logic       w_grant;
    logic [2:0] w_step;

    // With both requesters valid the holder of priority wins; otherwise the lone valid one.
    assign w_any   = bus.req0_valid | bus.req1_valid;
    assign w_grant = (bus.req0_valid & bus.req1_valid) ? r_prio : bus.req1_valid;
    assign w_step  = (r_rem > STEP_MAX) ? STEP_MAX[2:0] : r_rem[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= 8'h00;
            r_rem   <= 4'h0;
            r_id    <= 1'b0;
            r_prio  <= RR_INIT;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_rem   <= w_rem_nxt;
            r_id    <= w_id_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_rem;
        w_id_nxt    = r_id;
        w_prio_nxt  = r_prio;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_acc_nxt   = w_grant ? bus.req1_data : bus.req0_data;
                    w_rem_nxt   = w_grant ? bus.req1_amt  : bus.req0_amt;
                    w_id_nxt    = w_grant;
                    w_prio_nxt  = ~w_grant;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_acc_nxt = bus.sh_o;
                w_rem_nxt = r_rem - {1'b0, w_step};
                if (r_rem <= STEP_MAX) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.req0_ready = (r_state == IDLE) && w_any && !w_grant;
    assign bus.req1_ready = (r_state == IDLE) && w_any &&  w_grant;

    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_data  = (r_state == RESP) ? r_acc : 8'h00;
    assign bus.resp_id    = (r_state == RESP) ? r_id  : 1'b0;

    assign bus.sh_a = (r_state == SHIFT) ? r_acc : 8'h00;
    assign {bus.sh_s2, bus.sh_s1, bus.sh_s0} = (r_state == SHIFT) ? w_step : 3'd0;

    assign bus.busy = (r_state != IDLE);
endmodule

// File: tb/tb_shift_req_arbiter.sv
// tb/tb_shift_req_arbiter.sv - self-checking bench for shift_req_arbiter
module tb_shift_req_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    logic m_prio;

    shift_req_arbiter_if bus ();

    shift_req_arbiter #(.RR_INIT(1'b0), .MAX_STEP(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural external shifter
    assign bus.sh_o = bus.sh_a << {bus.sh_s2, bus.sh_s1, bus.sh_s0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [7:0] data;
        logic [3:0] amt;
        logic [7:0] exp_data;
        int         exp_pass;
        int         hold;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [3:0] a);
        int v;
        v = int'(d) * (1 << int'(a));
        return 8'(v % 256);
    endfunction

    function automatic int ref_pass(input logic [3:0] a);
        int n;
        n = (int'(a) + 6) / 7;
        return (n == 0) ? 1 : n;
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready0"},    int'(bus.req0_ready), 0);
        chk({tag, "_ready1"},    int'(bus.req1_ready), 0);
        chk({tag, "_resp_valid"}, int'(bus.resp_valid), 0);
        chk({tag, "_resp_data"}, int'(bus.resp_data), 0);
        chk({tag, "_resp_id"},   int'(bus.resp_id), 0);
        chk({tag, "_sh_a"},      int'(bus.sh_a), 0);
        chk({tag, "_sel"},       int'({bus.sh_s2, bus.sh_s1, bus.sh_s0}), 0);
        chk({tag, "_busy"},      int'(bus.busy), 0);
    endtask

    // Valids are already driven; returns the winner and what came back.
    task automatic run_txn(input int hold, output int w, output int rdata, output int rid,
                           output int npass, output int selsum);
        int   cyc;
        int   sel;
        logic v0, v1;
        @(negedge clk);
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        w = (v0 && v1) ? int'(m_prio) : (v1 ? 1 : 0);
        chk("grant_ready0", int'(bus.req0_ready), (w == 0) ? 1 : 0);
        chk("grant_ready1", int'(bus.req1_ready), (w == 1) ? 1 : 0);
        @(posedge clk);
        #1;
        if (w == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        m_prio = (w == 0);
        npass = 0; selsum = 0; cyc = 0; rdata = -1; rid = -1;
        forever begin
            @(negedge clk);
            if (bus.resp_valid) break;
            sel = int'({bus.sh_s2, bus.sh_s1, bus.sh_s0});
            selsum += sel;
            npass++;
            if (bus.req0_ready || bus.req1_ready)
                chk("no_accept_in_shift", 1, 0);
            cyc++;
            if (cyc >= 20) begin
                chk("resp_timeout", 0, 1);
                return;
            end
        end
        rdata = int'(bus.resp_data);
        rid   = int'(bus.resp_id);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(bus.resp_valid), 1);
            chk("hold_data", int'(bus.resp_data), rdata);
            chk("hold_id", int'(bus.resp_id), rid);
            chk("hold_readies", int'(bus.req0_ready | bus.req1_ready), 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        int w, rd, rid, np, ss;
        int order[4];
        logic [7:0] d;
        logic [3:0] a;
        n_checks = 0;
        n_err    = 0;
        m_prio   = 1'b0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_amt = 4'h0;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_amt = 4'h0;
        bus.resp_ready = 1'b0;

        vecs[0] = '{1'b0, 8'h81, 4'd1,  8'h02, 1, 0};
        vecs[1] = '{1'b1, 8'h01, 4'd15, 8'h00, 3, 0};
        vecs[2] = '{1'b0, 8'hA5, 4'd0,  8'hA5, 1, 0};
        vecs[3] = '{1'b1, 8'hFF, 4'd7,  8'h80, 1, 5};
        vecs[4] = '{1'b0, 8'hFF, 4'd8,  8'h00, 2, 0};
        vecs[5] = '{1'b1, 8'h3C, 4'd14, 8'h00, 2, 1};
        vecs[6] = '{1'b0, 8'h01, 4'd6,  8'h40, 1, 0};
        vecs[7] = '{1'b1, 8'hC3, 4'd2,  8'h0C, 1, 2};

        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Both requesters continuously valid from reset: alternating grants.
        bus.req0_valid = 1'b1; bus.req0_data = 8'h11; bus.req0_amt = 4'd1;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h22; bus.req1_amt = 4'd2;
        for (int k = 0; k < 4; k++) begin
            run_txn(0, w, rd, rid, np, ss);
            order[k] = w;
            chk("rr_resp_id", rid, w);
            if (w == 0) bus.req0_valid = 1'b1; else bus.req1_valid = 1'b1;
        end
        chk("rr_order0", order[0], 0);
        chk("rr_order1", order[1], 1);
        chk("rr_order2", order[2], 0);
        chk("rr_order3", order[3], 1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].req) begin
                bus.req1_data = vecs[i].data; bus.req1_amt = vecs[i].amt; bus.req1_valid = 1'b1;
            end else begin
                bus.req0_data = vecs[i].data; bus.req0_amt = vecs[i].amt; bus.req0_valid = 1'b1;
            end
            run_txn(vecs[i].hold, w, rd, rid, np, ss);
            chk($sformatf("vec%0d_data", i), rd, int'(vecs[i].exp_data));
            chk($sformatf("vec%0d_id", i), rid, int'(vecs[i].req));
            chk($sformatf("vec%0d_passes", i), np, vecs[i].exp_pass);
            chk($sformatf("vec%0d_selsum", i), ss, int'(vecs[i].amt));
        end

        // Reset during the second pass of an amt-15 request.
        bus.req1_data = 8'h01; bus.req1_amt = 4'd15; bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready1", int'(bus.req1_ready), 1);
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_pass2_sel", int'({bus.sh_s2, bus.sh_s1, bus.sh_s0}), 7);
        rst = 1'b1;
        #1;
        chk_reset_outs("rst_mid");
        m_prio = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rst_no_resp", int'(bus.resp_valid), 0);
        end
        @(posedge clk);
        #1;
        bus.req0_data = 8'h11; bus.req0_amt = 4'd3; bus.req0_valid = 1'b1;
        run_txn(0, w, rd, rid, np, ss);
        chk("after_rst_data", rd, 8'h88);
        chk("after_rst_id", rid, 0);
        chk("after_rst_passes", np, 1);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            if (!bus.req0_valid && ($urandom_range(0, 1) == 1)) begin
                bus.req0_data = 8'($urandom); bus.req0_amt = 4'($urandom); bus.req0_valid = 1'b1;
            end
            if (!bus.req1_valid && ($urandom_range(0, 1) == 1)) begin
                bus.req1_data = 8'($urandom); bus.req1_amt = 4'($urandom); bus.req1_valid = 1'b1;
            end
            if (!bus.req0_valid && !bus.req1_valid) begin
                bus.req0_data = 8'($urandom); bus.req0_amt = 4'($urandom); bus.req0_valid = 1'b1;
            end
            run_txn($urandom_range(0, 2), w, rd, rid, np, ss);
            d = (w == 1) ? bus.req1_data : bus.req0_data;
            a = (w == 1) ? bus.req1_amt  : bus.req0_amt;
            chk("rnd_data", rd, int'(ref_shift(d, a)));
            chk("rnd_id", rid, w);
            chk("rnd_passes", np, ref_pass(a));
            chk("rnd_selsum", ss, int'(a));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
